// File: rtl/lp_piped_mac.sv
// ---------------------------------------------------------------------------
// lp_piped_mac
//
// Pipelined multiply-add (result = a*b + c, modulo 2^ACC_WIDTH) with a
// launch/arrive handshake, ID tagging and downstream back-pressure.
// Empty stages (bubbles) are squeezed out while the output is stalled, and a
// launch into a completely full, stalled pipe is dropped and flagged.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous reset, active high
//   a, b, c      multiplicand, multiplier, addend
//   launch       start an operation this cycle
//   launch_id    tag carried with the operation
//   accept_n     low = consumer takes the arriving result this cycle
//   result       a*b+c of the output-stage entry (0 when no entry)
//   arrive       output stage holds a valid result
//   arrive_id    tag of the output-stage entry (0 when no entry)
//   pipe_full    launch cannot be accepted this cycle (combinational)
//   pipe_ovf     one-cycle pulse: a launch was dropped in the previous cycle
//   pipe_census  number of valid stages
// ---------------------------------------------------------------------------
module lp_piped_mac #(
    parameter  int unsigned A_WIDTH   = 8,
    parameter  int unsigned B_WIDTH   = 8,
    parameter  int unsigned ACC_WIDTH = 20,
    parameter  int unsigned ID_WIDTH  = 8,
    parameter  int unsigned STAGES    = 3,
    parameter  int unsigned TC_MODE   = 0,
    localparam int unsigned CW        = $clog2(STAGES + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [A_WIDTH-1:0]   a,
    input  logic [B_WIDTH-1:0]   b,
    input  logic [ACC_WIDTH-1:0] c,
    input  logic                 launch,
    input  logic [ID_WIDTH-1:0]  launch_id,
    input  logic                 accept_n,
    output logic [ACC_WIDTH-1:0] result,
    output logic                 arrive,
    output logic [ID_WIDTH-1:0]  arrive_id,
    output logic                 pipe_full,
    output logic                 pipe_ovf,
    output logic [CW-1:0]        pipe_census
);

    // Stage k (1..STAGES) state; stage STAGES is the output stage.
    logic [STAGES:1]       v_q;
    logic [ACC_WIDTH-1:0]  d_q  [1:STAGES];
    logic [ID_WIDTH-1:0]   id_q [1:STAGES];
    logic [STAGES:1]       go;
    logic [CW-1:0]         census_q;
    logic                  ovf_q;

    logic                  take;
    logic                  retire;
    logic                  a_sx;
    logic                  b_sx;
    logic [ACC_WIDTH-1:0]  a_ext;
    logic [ACC_WIDTH-1:0]  b_ext;
    logic [ACC_WIDTH-1:0]  mac;

    // Operand extension and multiply-add. Operands are held at zero unless a
    // launch is requested so the multiplier does not toggle while idle.
    always_comb begin
        a_sx  = (TC_MODE != 0) && a[A_WIDTH-1];
        b_sx  = (TC_MODE != 0) && b[B_WIDTH-1];
        a_ext = '0;
        b_ext = '0;
        if (launch) begin
            a_ext = {{(ACC_WIDTH - A_WIDTH){a_sx}}, a};
            b_ext = {{(ACC_WIDTH - B_WIDTH){b_sx}}, b};
        end
        mac = a_ext * b_ext + c;
    end

    // Advance enables. The recursive rule go[i] = ~v[i+1] | go[i+1] is
    // flattened: stage i may advance unless the output stalls and every stage
    // below it is occupied. A running AND avoids a combinational self-loop.
    always_comb begin
        logic stall_tail;
        stall_tail  = accept_n & v_q[STAGES];
        go          = '0;
        go[STAGES]  = ~stall_tail;
        for (int unsigned j = 1; j < STAGES; j++) begin
            go[STAGES - j] = ~stall_tail;
            stall_tail     = stall_tail & v_q[STAGES - j];
        end
    end

    assign take      = launch & (~v_q[1] | go[1]);
    assign retire    = v_q[STAGES] & ~accept_n;
    assign pipe_full = v_q[1] & ~go[1];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q      <= '0;
            census_q <= '0;
            ovf_q    <= 1'b0;
            for (int unsigned k = 1; k <= STAGES; k++) begin
                d_q[k]  <= '0;
                id_q[k] <= '0;
            end
        end else begin
            ovf_q <= launch & pipe_full;

            if (take) begin
                v_q[1]  <= 1'b1;
                d_q[1]  <= mac;
                id_q[1] <= launch_id;
            end else if (go[1]) begin
                v_q[1] <= 1'b0;
            end

            // Payload only moves behind a valid entry, keeping idle stages
            // from toggling.
            for (int unsigned k = 2; k <= STAGES; k++) begin
                if (go[k-1]) begin
                    v_q[k] <= v_q[k-1];
                    if (v_q[k-1]) begin
                        d_q[k]  <= d_q[k-1];
                        id_q[k] <= id_q[k-1];
                    end
                end
            end

            case ({take, retire})
                2'b10:   census_q <= census_q + CW'(1);
                2'b01:   census_q <= census_q - CW'(1);
                default: census_q <= census_q;
            endcase
        end
    end

    assign arrive      = v_q[STAGES];
    assign result      = v_q[STAGES] ? d_q[STAGES]  : '0;
    assign arrive_id   = v_q[STAGES] ? id_q[STAGES] : '0;
    assign pipe_ovf    = ovf_q;
    assign pipe_census = census_q;

endmodule

// File: tb/tb_lp_piped_mac.sv
// ---------------------------------------------------------------------------
// tb_lp_piped_mac
//
// Two instances of lp_piped_mac (unsigned and two's complement) share one
// stimulus stream. Each step row carries the inputs for one cycle plus the
// expected arrive / census / pipe_full / pipe_ovf seen during that cycle.
// Expected results and tags are queued when a launch is expected to be
// accepted and compared whenever an entry is expected at the output.
// ---------------------------------------------------------------------------
module tb_lp_piped_mac;

    typedef struct {
        logic        rst;
        logic        launch;
        logic        acc_n;
        logic [7:0]  a;
        logic [7:0]  b;
        logic [19:0] c;
        logic [7:0]  id;
        logic [19:0] r0;     // expected result, unsigned instance
        logic [19:0] r1;     // expected result, two's complement instance
        logic        e_arr;
        int          e_cen;
        logic        e_full;
        logic        e_ovf;
    } step_t;

    typedef struct {
        logic [19:0] r0;
        logic [19:0] r1;
        logic [7:0]  id;
    } exp_t;

    logic        clk;
    logic        rst;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [19:0] c;
    logic        launch;
    logic [7:0]  launch_id;
    logic        accept_n;

    logic [19:0] result0, result1;
    logic        arrive0, arrive1;
    logic [7:0]  aid0, aid1;
    logic        full0, full1;
    logic        ovf0, ovf1;
    logic [1:0]  cen0, cen1;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    step_t tbl[44];

    lp_piped_mac #(
        .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(20), .ID_WIDTH(8),
        .STAGES(3), .TC_MODE(0)
    ) u_dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .launch(launch), .launch_id(launch_id), .accept_n(accept_n),
        .result(result0), .arrive(arrive0), .arrive_id(aid0),
        .pipe_full(full0), .pipe_ovf(ovf0), .pipe_census(cen0)
    );

    lp_piped_mac #(
        .A_WIDTH(8), .B_WIDTH(8), .ACC_WIDTH(20), .ID_WIDTH(8),
        .STAGES(3), .TC_MODE(1)
    ) u_dut_tc (
        .clk(clk), .rst(rst), .a(a), .b(b), .c(c),
        .launch(launch), .launch_id(launch_id), .accept_n(accept_n),
        .result(result1), .arrive(arrive1), .arrive_id(aid1),
        .pipe_full(full1), .pipe_ovf(ovf1), .pipe_census(cen1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic step_t mk(input logic rst_i, input logic launch_i, input logic acc_i,
                                 input logic [7:0] a_i, input logic [7:0] b_i,
                                 input logic [19:0] c_i, input logic [7:0] id_i,
                                 input logic [19:0] r0_i, input logic [19:0] r1_i,
                                 input logic arr_i, input int cen_i,
                                 input logic full_i, input logic ovf_i);
        step_t s;
        s.rst = rst_i; s.launch = launch_i; s.acc_n = acc_i;
        s.a = a_i; s.b = b_i; s.c = c_i; s.id = id_i;
        s.r0 = r0_i; s.r1 = r1_i;
        s.e_arr = arr_i; s.e_cen = cen_i; s.e_full = full_i; s.e_ovf = ovf_i;
        return s;
    endfunction

    function automatic step_t idle(input logic acc_i, input logic arr_i, input int cen_i,
                                   input logic full_i, input logic ovf_i);
        return mk(1'b0, 1'b0, acc_i, 8'd0, 8'd0, 20'd0, 8'd0, 20'd0, 20'd0,
                  arr_i, cen_i, full_i, ovf_i);
    endfunction

    // Launch with a = id, b = 1, c = 0, so result = id in both modes.
    function automatic step_t lk(input logic acc_i, input logic [7:0] id_i, input logic arr_i,
                                 input int cen_i, input logic full_i, input logic ovf_i);
        return mk(1'b0, 1'b1, acc_i, id_i, 8'd1, 20'd0, id_i, {12'd0, id_i}, {12'd0, id_i},
                  arr_i, cen_i, full_i, ovf_i);
    endfunction

    task automatic step(input step_t s);
        @(negedge clk);
        rst       = s.rst;
        launch    = s.launch;
        accept_n  = s.acc_n;
        a         = s.a;
        b         = s.b;
        c         = s.c;
        launch_id = s.id;
        #1;
        chk("arrive",       {31'd0, arrive0}, {31'd0, s.e_arr});
        chk("arrive_tc",    {31'd0, arrive1}, {31'd0, s.e_arr});
        chk("census",       {30'd0, cen0},    s.e_cen);
        chk("census_tc",    {30'd0, cen1},    s.e_cen);
        chk("pipe_full",    {31'd0, full0},   {31'd0, s.e_full});
        chk("pipe_full_tc", {31'd0, full1},   {31'd0, s.e_full});
        chk("pipe_ovf",     {31'd0, ovf0},    {31'd0, s.e_ovf});
        chk("pipe_ovf_tc",  {31'd0, ovf1},    {31'd0, s.e_ovf});
        if (s.e_arr) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_underflow: arrival expected but scoreboard empty (t=%0t)", $time);
            end else begin
                chk("result",       {12'd0, result0}, {12'd0, sb[0].r0});
                chk("result_tc",    {12'd0, result1}, {12'd0, sb[0].r1});
                chk("arrive_id",    {24'd0, aid0},    {24'd0, sb[0].id});
                chk("arrive_id_tc", {24'd0, aid1},    {24'd0, sb[0].id});
            end
        end else begin
            chk("idle_result",    {12'd0, result0}, 32'd0);
            chk("idle_result_tc", {12'd0, result1}, 32'd0);
            chk("idle_id",        {24'd0, aid0},    32'd0);
            chk("idle_id_tc",     {24'd0, aid1},    32'd0);
        end
        if (s.rst) begin
            sb.delete();
        end else begin
            if (s.e_arr && !s.acc_n && sb.size() != 0) void'(sb.pop_front());
            if (s.launch && !s.e_full) sb.push_back('{r0: s.r0, r1: s.r1, id: s.id});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Latency 3, unsigned and signed arithmetic, wrap case
        tbl[0]  = mk(0, 1, 0, 8'd200, 8'd100, 20'd5, 8'h3C, 20'd20005, 20'hFEA25, 0, 0, 0, 0);
        tbl[1]  = idle(0, 0, 1, 0, 0);
        tbl[2]  = idle(0, 0, 1, 0, 0);
        tbl[3]  = idle(0, 1, 1, 0, 0);
        tbl[4]  = idle(0, 0, 0, 0, 0);
        tbl[5]  = mk(0, 1, 0, 8'hFE, 8'd3, 20'hFFFFF, 8'h11, 20'h002F9, 20'hFFFF9, 0, 0, 0, 0);
        tbl[6]  = mk(0, 1, 0, 8'h80, 8'h80, 20'h7FFFF, 8'h12, 20'h83FFF, 20'h83FFF, 0, 1, 0, 0);
        tbl[7]  = idle(0, 0, 2, 0, 0);
        tbl[8]  = idle(0, 1, 2, 0, 0);
        tbl[9]  = idle(0, 1, 1, 0, 0);
        tbl[10] = idle(0, 0, 0, 0, 0);
        // Stall and fill, drop of id 4, release
        tbl[11] = lk(1, 8'd1, 0, 0, 0, 0);
        tbl[12] = lk(1, 8'd2, 0, 1, 0, 0);
        tbl[13] = lk(1, 8'd3, 0, 2, 0, 0);
        tbl[14] = lk(1, 8'd4, 1, 3, 1, 0);
        tbl[15] = idle(1, 1, 3, 1, 1);
        tbl[16] = idle(0, 1, 3, 0, 0);
        tbl[17] = idle(0, 1, 2, 0, 0);
        tbl[18] = idle(0, 1, 1, 0, 0);
        tbl[19] = idle(0, 0, 0, 0, 0);
        // Bubble collapse behind a stalled output
        tbl[20] = lk(1, 8'd5, 0, 0, 0, 0);
        tbl[21] = idle(1, 0, 1, 0, 0);
        tbl[22] = idle(1, 0, 1, 0, 0);
        tbl[23] = lk(1, 8'd6, 1, 1, 0, 0);
        tbl[24] = idle(1, 1, 2, 0, 0);
        tbl[25] = idle(1, 1, 2, 0, 0);
        tbl[26] = idle(0, 1, 2, 0, 0);
        tbl[27] = idle(0, 1, 1, 0, 0);
        tbl[28] = idle(0, 0, 0, 0, 0);
        // Full pipe: retire+launch together, consecutive drops, mid-flight reset
        tbl[29] = lk(1, 8'd7,  0, 0, 0, 0);
        tbl[30] = lk(1, 8'd8,  0, 1, 0, 0);
        tbl[31] = lk(1, 8'd9,  0, 2, 0, 0);
        tbl[32] = lk(0, 8'd10, 1, 3, 0, 0);
        tbl[33] = lk(0, 8'd11, 1, 3, 0, 0);
        tbl[34] = lk(1, 8'd12, 1, 3, 1, 0);
        tbl[35] = lk(1, 8'd13, 1, 3, 1, 1);
        tbl[36] = idle(1, 1, 3, 1, 1);
        tbl[37] = mk(1, 1, 0, 8'd14, 8'd1, 20'd0, 8'd14, 20'd14, 20'd14, 1, 3, 0, 0);
        tbl[38] = idle(0, 0, 0, 0, 0);
        tbl[39] = lk(0, 8'd15, 0, 0, 0, 0);
        tbl[40] = idle(0, 0, 1, 0, 0);
        tbl[41] = idle(0, 0, 1, 0, 0);
        tbl[42] = idle(0, 1, 1, 0, 0);
        tbl[43] = idle(0, 0, 0, 0, 0);

        // Reset held for two cycles with launch asserted
        rst       = 1'b1;
        launch    = 1'b1;
        accept_n  = 1'b0;
        a         = 8'hFF;
        b         = 8'hFF;
        c         = 20'hFFFFF;
        launch_id = 8'hEE;
        repeat (2) @(posedge clk);

        foreach (tbl[i]) step(tbl[i]);

        // Sustained throughput: six back-to-back launches, no stall
        for (int k = 0; k < 10; k++) begin
            step_t s;
            logic  arr;
            int    cen;
            logic [19:0] r;
            arr = (k >= 3) && (k <= 8);
            cen = (k <= 3) ? k : ((k <= 6) ? 3 : 9 - k);
            r   = 20'((k + 1) * (k + 2) + k);
            if (k < 6)
                s = mk(0, 1, 0, 8'(k + 1), 8'(k + 2), 20'(k), 8'(8'h40 + k), r, r, arr, cen, 0, 0);
            else
                s = idle(0, arr, cen, 0, 0);
            step(s);
        end

        chk("sb_drained", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
